// File: rtl/ram1_spram.sv
// Single-port byte-enabled block RAM, normal-write mode, registered read port.
// Define RAM1_SPRAM_OUTPUT_REG_EN to add a second output register (2-cycle read latency).
module ram1_spram #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4,
  parameter int BYTE_SIZE  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic [BE_WIDTH-1:0]   wr_byte_en,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] arr_word;
  logic [DATA_WIDTH-1:0] rd_q;

  // One array per lane so each maps onto its own block RAM column.
  for (genvar i = 0; i < BE_WIDTH; i++) begin : g_lane
    logic [BYTE_SIZE-1:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (rst && wr_en && wr_byte_en[i]) begin
        lane_mem[addr] <= wr_data[i*BYTE_SIZE +: BYTE_SIZE];
      end
    end

    assign arr_word[i*BYTE_SIZE +: BYTE_SIZE] = lane_mem[addr];
  end

  // Write cycles leave the read register untouched (no write-through).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
    end else if (!wr_en) begin
      rd_q <= arr_word;
    end
  end

`ifdef RAM1_SPRAM_OUTPUT_REG_EN
  logic [DATA_WIDTH-1:0] rd_pipe_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pipe_q <= '0;
    end else begin
      rd_pipe_q <= rd_q;
    end
  end

  assign rd_data = rd_pipe_q;
`else
  assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_ram1_spram.sv
// Directed bench for ram1_spram; follows RAM1_SPRAM_OUTPUT_REG_EN for read latency.
module tb_ram1_spram;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int DEPTH = 1 << AW;
`ifdef RAM1_SPRAM_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rst;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic [BW-1:0] wr_byte_en;
  logic [DW-1:0] rd_data;

  int pass_cnt  = 0;
  int check_cnt = 0;

  int            s_addr [$];
  logic [DW-1:0] s_exp  [$];

  ram1_spram dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .wr_byte_en (wr_byte_en),
    .rd_data    (rd_data)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard check
  task automatic check(input string tag, input logic [DW-1:0] exp);
    check_cnt++;
    assert (rd_data === exp) pass_cnt++;
    else $error("FAIL %s: rd_data=%h expected=%h", tag, rd_data, exp);
  endtask

  // Drivers: each task starts and ends 1 time unit after a rising edge.
  task automatic do_write(input int a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    addr       = AW'(a);
    wr_data    = d;
    wr_byte_en = be;
    wr_en      = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic do_read(input string tag, input int a, input logic [DW-1:0] exp);
    addr  = AW'(a);
    wr_en = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  // Pipelined reads, one new address per cycle, from s_addr / s_exp.
  task automatic run_stream(input string tag);
    int n;
    n = s_addr.size();
    for (int i = 0; i < n + LAT - 1; i++) begin
      if (i < n) addr = AW'(s_addr[i]);
      wr_en = 1'b0;
      @(posedge clk);
      #1;
      if (i >= LAT - 1) check(tag, s_exp[i-LAT+1]);
    end
    s_addr.delete();
    s_exp.delete();
  endtask

  initial begin
    rst        = 1'b0;
    addr       = '0;
    wr_data    = '0;
    wr_en      = 1'b0;
    wr_byte_en = '0;
    #1;
    check("reset_init", 32'h0000_0000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", 32'h0000_0000);
    rst = 1'b1;

    // Full sweep
    for (int a = 0; a < DEPTH; a++) do_write(a, 32'hFFFF_FFFF - DW'(a), 4'hF);
    for (int a = 0; a < DEPTH; a++) begin
      s_addr.push_back(a);
      s_exp.push_back(32'hFFFF_FFFF - DW'(a));
    end
    run_stream("sweep");

    // Byte enables
    do_write(16'h0010, 32'h1122_3344, 4'hF);
    do_write(16'h0010, 32'hAABB_CCDD, 4'h5);
    do_read("byte_en_partial", 16'h0010, 32'h11BB_33DD);
    do_write(16'h0010, 32'h0000_0000, 4'h0);
    do_read("byte_en_none", 16'h0010, 32'h11BB_33DD);

    // Normal-write hold
    do_write(16'h0001, 32'hCAFE_F00D, 4'hF);
    do_read("hold_read", 16'h0001, 32'hCAFE_F00D);
    do_write(16'h0100, 32'h0101_0101, 4'hF);
    check("hold_w1", 32'hCAFE_F00D);
    do_write(16'h0200, 32'h0202_0202, 4'hF);
    check("hold_w2", 32'hCAFE_F00D);
    do_write(16'h0300, 32'h0303_0303, 4'h3);
    check("hold_w3", 32'hCAFE_F00D);
    do_read("hold_readback", 16'h0300, 32'hFFFF_0303);

    // Boundary and back-to-back
    do_write(16'h3FFF, 32'hDEAD_BEEF, 4'hF);
    do_read("top_addr_next", 16'h3FFF, 32'hDEAD_BEEF);
    for (int k = 0; k < 6; k++) begin
      s_addr.push_back((k % 2 == 0) ? 0 : 16'h3FFF);
      s_exp.push_back((k % 2 == 0) ? 32'hFFFF_FFFF : 32'hDEAD_BEEF);
    end
    run_stream("alternate");

    // Asynchronous reset mid-run; memory must survive, writes suppressed
    do_write(16'h0020, 32'hA5A5_A5A5, 4'hF);
    do_write(16'h0030, 32'h1234_5678, 4'hF);
    do_read("pre_reset", 16'h0030, 32'h1234_5678);
    #2;
    rst = 1'b0;
    #1;
    check("reset_async", 32'h0000_0000);
    addr       = 16'h0020;
    wr_data    = 32'h0000_0000;
    wr_byte_en = 4'hF;
    wr_en      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 32'h0000_0000);
    wr_en = 1'b0;
    rst   = 1'b1;
    do_read("post_reset", 16'h0020, 32'hA5A5_A5A5);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
